// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port.
// A one-entry output stage holds the winning write under back-pressure.
module reg_write_arbiter #(
  parameter int N_REQ      = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        wr_ready,
  output logic                        wr_enable,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [DATA_WIDTH-1:0]       wr_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      win;
  logic [PTR_W-1:0]      next_ptr;
  logic                  found;
  logic                  can_accept;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] addr_arr [N_REQ];
  logic [DATA_WIDTH-1:0] data_arr [N_REQ];
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    if (int'(win) == N_REQ - 1) next_ptr = '0;
    else                        next_ptr = win + 1'b1;
  end

  assign win_addr   = addr_arr[win];
  assign win_data   = data_arr[win];
  assign can_accept = !wr_enable || wr_ready;
  assign xfer       = !reset && can_accept && found;
  assign req_ready  = xfer ? (N_REQ'(1) << win) : '0;

  // Writes to r0 are consumed but never presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      wr_enable <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else if (xfer) begin
      rr_ptr    <= next_ptr;
      wr_enable <= |win_addr;
      wr_addr   <= win_addr;
      wr_data   <= win_data;
    end else if (wr_enable && wr_ready) begin
      wr_enable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter.
// A queue-free reference model tracks priority and the output stage.
module tb_reg_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wr_ready;
  logic            wr_enable;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;

  int checks = 0;
  int errors = 0;

  int          m_ptr;
  bit          m_v;
  int          m_a;
  logic [31:0] m_d;
  logic [N-1:0] last_ready;

  reg_write_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .wr_ready(wr_ready), .wr_enable(wr_enable),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic set_req(int i, bit v, int a, logic [31:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*DW +: DW] = d;
  endtask

  function automatic int get_addr(int i);
    return int'(req_addr[i*AW +: AW]);
  endfunction

  function automatic logic [31:0] get_data(int i);
    return req_data[i*DW +: DW];
  endfunction

  // One clock: compare mid-cycle against the model, then advance it.
  task automatic step(string tag);
    int win;
    bit acc;
    logic [N-1:0] exp_r;
    #4;
    win = -1;
    for (int k = 0; k < N; k++)
      if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    acc = !m_v || wr_ready;
    exp_r = '0;
    if (!reset && acc && win >= 0) exp_r[win] = 1'b1;
    last_ready = req_ready;
    checks++;
    if (req_ready !== exp_r) begin
      errors++;
      $display("FAIL %s req_ready got %b exp %b", tag, req_ready, exp_r);
    end
    checks++;
    if (wr_enable !== m_v) begin
      errors++;
      $display("FAIL %s wr_enable got %b exp %b", tag, wr_enable, m_v);
    end
    checks++;
    if (int'(wr_addr) !== m_a || wr_data !== m_d) begin
      errors++;
      $display("FAIL %s wr_addr/data got %0d/%h exp %0d/%h",
               tag, wr_addr, wr_data, m_a, m_d);
    end
    @(posedge clk);
    if (reset) begin
      m_ptr = 0; m_v = 0; m_a = 0; m_d = '0;
    end else if (acc && win >= 0) begin
      m_ptr = (win + 1) % N;
      m_a   = get_addr(win);
      m_d   = get_data(win);
      m_v   = (m_a != 0);
    end else if (m_v && wr_ready) begin
      m_v = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step("reset_pulse");
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, i + 1, 32'hA0 + i);
    for (int c = 0; c < 2; c++) begin
      step("reset_hold");
      checks++;
      if (last_ready !== 3'b000) begin
        errors++;
        $display("FAIL reset_ready got %b exp 000", last_ready);
      end
    end
    reset = 1'b0;
    req_valid = '0;
    checks++;
    if (wr_enable !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_state got %b/%0d/%h exp 0/0/0",
               wr_enable, wr_addr, wr_data);
    end
    step("post_reset");
  endtask

  task automatic test_single();
    do_reset();
    wr_ready = 1'b1;
    set_req(1, 1, 5, 32'hDEADBEEF);
    step("single_acc");
    checks++;
    if (last_ready !== 3'b010) begin
      errors++;
      $display("FAIL single_ready got %b exp 010", last_ready);
    end
    req_valid = '0;
    checks++;
    if (wr_enable !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_out got %b/%0d/%h exp 1/5/deadbeef",
               wr_enable, wr_addr, wr_data);
    end
    step("single_out");
    checks++;
    if (wr_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_drop got %b exp 0", wr_enable);
    end
  endtask

  task automatic test_round_robin();
    int g;
    reset = 1'b1;
    wr_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, i + 1, $urandom);
    step("rr_reset");
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      step("rr");
      g = -1;
      for (int i = 0; i < N; i++) if (last_ready[i]) g = i;
      checks++;
      if (g != n % N) begin
        errors++;
        $display("FAIL rr_order got %0d exp %0d", g, n % N);
      end
      checks++;
      if (wr_enable !== 1'b1) begin
        errors++;
        $display("FAIL rr_enable got %b exp 1", wr_enable);
      end
      if (g >= 0) set_req(g, 1, g + 1, $urandom);
    end
    req_valid = '0;
    step("rr_tail");
  endtask

  task automatic test_back_pressure();
    do_reset();
    wr_ready = 1'b1;
    set_req(0, 1, 7, 32'h7777);
    step("bp_fill");
    set_req(0, 1, 9, 32'h9999);
    wr_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step("bp_hold");
      checks++;
      if (last_ready !== 3'b000 || wr_addr !== 5'd7 || wr_data !== 32'h7777) begin
        errors++;
        $display("FAIL bp_hold got %b/%0d/%h exp 000/7/7777",
                 last_ready, wr_addr, wr_data);
      end
    end
    wr_ready = 1'b1;
    step("bp_release");
    checks++;
    if (last_ready !== 3'b001) begin
      errors++;
      $display("FAIL bp_release got %b exp 001", last_ready);
    end
    req_valid = '0;
    checks++;
    if (wr_enable !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'h9999) begin
      errors++;
      $display("FAIL bp_next got %b/%0d/%h exp 1/9/9999",
               wr_enable, wr_addr, wr_data);
    end
    step("bp_drain");
  endtask

  task automatic test_r0_write();
    do_reset();
    wr_ready = 1'b1;
    set_req(1, 1, 3, 32'h33);
    step("r0_ptr");
    req_valid = '0;
    set_req(2, 1, 0, 32'h1234);
    step("r0_acc");
    checks++;
    if (last_ready !== 3'b100) begin
      errors++;
      $display("FAIL r0_ready got %b exp 100", last_ready);
    end
    req_valid = '0;
    set_req(0, 1, 4, 32'h44);
    set_req(1, 1, 6, 32'h66);
    checks++;
    if (wr_enable !== 1'b0) begin
      errors++;
      $display("FAIL r0_enable got %b exp 0", wr_enable);
    end
    step("r0_next");
    checks++;
    if (last_ready !== 3'b001) begin
      errors++;
      $display("FAIL r0_wrap got %b exp 001", last_ready);
    end
    req_valid = '0;
    step("r0_tail");
  endtask

  task automatic test_reset_midop();
    do_reset();
    wr_ready = 1'b1;
    set_req(1, 1, 4, 32'h4444);
    step("mid_fill");
    req_valid = '0;
    wr_ready = 1'b0;
    step("mid_full");
    reset = 1'b1;
    step("mid_reset");
    reset = 1'b0;
    set_req(0, 1, 8, 32'h8888);
    set_req(1, 1, 10, 32'hAAAA);
    checks++;
    if (wr_enable !== 1'b0) begin
      errors++;
      $display("FAIL mid_enable got %b exp 0", wr_enable);
    end
    step("mid_regrant");
    checks++;
    if (last_ready !== 3'b001) begin
      errors++;
      $display("FAIL mid_ptr got %b exp 001", last_ready);
    end
    req_valid = '0;
    wr_ready = 1'b1;
    checks++;
    if (wr_addr !== 5'd8) begin
      errors++;
      $display("FAIL mid_stale got %0d exp 8", wr_addr);
    end
    step("mid_tail");
  endtask

  task automatic test_random();
    do_reset();
    req_valid = '0;
    for (int n = 0; n < 400; n++) begin
      wr_ready = ($urandom_range(0, 9) < 7);
      step("rand");
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && last_ready[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) != 0)
          set_req(i, 1, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 31),
                  $urandom);
      end
      if (n == 200) begin
        reset = 1'b1;
        step("rand_reset");
        reset = 1'b0;
      end
    end
    req_valid = '0;
    step("rand_tail");
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    wr_ready = 1'b1;
    m_ptr = 0; m_v = 0; m_a = 0; m_d = '0;
    last_ready = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_r0_write();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
